cpu_control_fsm: RTL and testbench

//  Multi-cycle control sequencer for the 10-bit CPU. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB,

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/cpu_control_fsm_mem_wait_timer.sv | 29 ++
 rtl/cpu_control_fsm.sv | 154 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA and control encodings for the 10-bit CPU control sequencer.
// instr = op[9:7] rd[6:5] rs[4:3] imm[2:0].
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_JR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_PASS_B = 2'b10;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       wb_sel;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic       halted;
    logic       fault;
  } ctrl_t;

  // ALU operand/operation setup for an opcode; kept stable through EXEC, MEM and WB.
  function automatic ctrl_t with_alu(input ctrl_t c, input logic [2:0] op);
    ctrl_t r;
    r = c;
    unique case (op)
      OP_ADD:               begin r.alu_op = ALU_ADD; r.alu_src_imm = 1'b0; end
      OP_SUB, OP_BEQ:       begin r.alu_op = ALU_SUB; r.alu_src_imm = 1'b0; end
      OP_ADDI, OP_LW, OP_SW: begin r.alu_op = ALU_ADD; r.alu_src_imm = 1'b1; end
      default:              begin r.alu_op = ALU_ADD; r.alu_src_imm = 1'b0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_mem_wait_timer.sv
// Counts memory-request cycles without an acknowledge and flags the cycle on
// which the wait budget is exhausted.
module mem_wait_timer #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the cycle whose increment would bring the count to ACK_TIMEOUT.
  assign expired = en && (cnt == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 10-bit CPU; drives
// datapath enables/muxes and handshakes with the shared memory port.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] ir_op,
  input  logic            alu_zero,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            alu_src_imm,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            fault
);

  state_t          state;
  state_t          state_nxt;
  logic [OP_W-1:0] op_q;
  logic            active;
  logic            req_phase;
  logic            timer_en;
  logic            timer_expired;
  ctrl_t           ctl;

  // active holds every output low from reset until the first edge after release,
  // so a request never appears while rst_n is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      op_q   <= '0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (active) begin
        state <= state_nxt;
        if (state == ST_DECODE) begin
          op_q <= ir_op;
        end
      end
    end
  end

  assign req_phase = active && ((state == ST_FETCH) || (state == ST_MEM));
  assign timer_en  = req_phase && !mem_ack;

  mem_wait_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (8)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!timer_en),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    if (active) begin
      case (state)
        ST_FETCH: begin
          ctl.mem_req = 1'b1;
          if (mem_ack) begin
            ctl.ir_we  = 1'b1;
            ctl.pc_we  = 1'b1;
            ctl.pc_src = PC_INC;
            state_nxt  = ST_DECODE;
          end else if (timer_expired) begin
            state_nxt = ST_FAULT;
          end
        end
        ST_DECODE: begin
          state_nxt = (ir_op == OP_HALT) ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          ctl = with_alu(ctl, op_q);
          case (op_q)
            OP_ADD, OP_SUB, OP_ADDI: state_nxt = ST_WB;
            OP_LW, OP_SW:            state_nxt = ST_MEM;
            OP_BEQ: begin
              ctl.pc_we  = alu_zero;
              ctl.pc_src = PC_BRANCH;
              state_nxt  = ST_FETCH;
            end
            OP_JR: begin
              ctl.pc_we  = 1'b1;
              ctl.pc_src = PC_REG;
              state_nxt  = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          ctl          = with_alu(ctl, op_q);
          ctl.mem_req  = 1'b1;
          ctl.addr_sel = 1'b1;
          ctl.mem_we   = (op_q == OP_SW);
          if (mem_ack) begin
            // Loads write back in the acknowledge cycle; there is no WB visit.
            if (op_q == OP_LW) begin
              ctl.reg_we = 1'b1;
              ctl.wb_sel = 1'b1;
            end
            state_nxt = ST_FETCH;
          end else if (timer_expired) begin
            state_nxt = ST_FAULT;
          end
        end
        ST_WB: begin
          ctl        = with_alu(ctl, op_q);
          ctl.reg_we = 1'b1;
          ctl.wb_sel = 1'b0;
          state_nxt  = ST_FETCH;
        end
        ST_HALT: begin
          ctl.halted = 1'b1;
        end
        ST_FAULT: begin
          ctl.fault = 1'b1;
        end
        default: begin
          state_nxt = ST_FAULT;
        end
      endcase
    end
  end

  assign mem_req     = ctl.mem_req;
  assign mem_we      = ctl.mem_we;
  assign addr_sel    = ctl.addr_sel;
  assign ir_we       = ctl.ir_we;
  assign pc_we       = ctl.pc_we;
  assign pc_src      = ctl.pc_src;
  assign reg_we      = ctl.reg_we;
  assign wb_sel      = ctl.wb_sel;
  assign alu_src_imm = ctl.alu_src_imm;
  assign alu_op      = ctl.alu_op;
  assign halted      = ctl.halted;
  assign fault       = ctl.fault;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench: the stimulus expands each instruction into its expected
// per-cycle control vectors; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_cpu_control_fsm;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADDI = 3'd2, LW = 3'd3,
                         SW = 3'd4, BEQ = 3'd5, JR = 3'd6, HALT = 3'd7;
  localparam int TO = 15;
  localparam logic [13:0] ALU_BITS  = 14'h001C;
  localparam logic [13:0] PSRC_BITS = 14'h0180;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ir_op = 3'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, wb_sel;
  logic       alu_src_imm, halted, fault;
  logic [1:0] pc_src, alu_op;

  always #5 clk = ~clk;

  cpu_control_fsm #(.OP_W(3), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ir_op(ir_op), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .halted(halted), .fault(fault)
  );

  // {req, we, addr_sel, ir_we, pc_we, pc_src[1:0], reg_we, wb_sel, imm, alu_op[1:0], halted, fault}
  logic [13:0] obs;
  assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
                alu_src_imm, alu_op, halted, fault};

  typedef struct {
    logic [13:0] v;
    logic [13:0] care;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [13:0] mk(input bit req, input bit we, input bit asel,
                                     input bit irw, input bit pcw, input logic [1:0] psrc,
                                     input bit rw, input bit wbs, input bit imm,
                                     input logic [1:0] aop, input bit h, input bit f);
    return {req, we, asel, irw, pcw, psrc, rw, wbs, imm, aop, h, f};
  endfunction

  // One clock of stimulus: drive inputs, queue the expected outputs, advance.
  task automatic step(input logic [13:0] v, input bit alu_care, input bit ack,
                      input bit zero, input logic [2:0] op, input string nm);
    exp_t e;
    e.v    = v;
    e.care = ~14'h0;
    if (!alu_care) e.care = e.care & ~ALU_BITS;
    if (!v[9])     e.care = e.care & ~PSRC_BITS;
    e.name = nm;
    mem_ack  = ack;
    alu_zero = zero;
    ir_op    = op;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic fault_tail();
    for (int i = 0; i < 10; i++)
      step(mk(0,0,0,0,0,2'b00,0,0,0,2'b00,0,1), 1'b1, rb(), rb(), rop(), "fault_sticky");
  endtask

  // Reference timeline of one instruction from the ISA's phase rules.
  task automatic run(input logic [2:0] op, input int fw, input int mw, input bit zero);
    bit         imm;
    bit         is_sw;
    bit         is_lw;
    logic [1:0] aop;
    imm   = (op == ADDI) || (op == LW) || (op == SW);
    aop   = ((op == SUB) || (op == BEQ)) ? 2'b01 : 2'b00;
    is_sw = (op == SW);
    is_lw = (op == LW);
    for (int i = 0; i < ((fw < TO) ? fw : TO); i++)
      step(mk(1,0,0,0,0,2'b00,0,0,0,2'b00,0,0), 1'b0, 1'b0, rb(), rop(), "fetch_wait");
    if (fw >= TO) begin
      fault_tail();
      return;
    end
    step(mk(1,0,0,1,1,2'b00,0,0,0,2'b00,0,0), 1'b0, 1'b1, rb(), rop(), "fetch_ack");
    step(mk(0,0,0,0,0,2'b00,0,0,0,2'b00,0,0), 1'b0, rb(), rb(), op, "decode");
    if (op == HALT) begin
      for (int i = 0; i < 20; i++)
        step(mk(0,0,0,0,0,2'b00,0,0,0,2'b00,1,0), 1'b1, rb(), rb(), rop(), "halt_sticky");
      return;
    end
    case (op)
      BEQ: step(mk(0,0,0,0,zero,2'b01,0,0,0,2'b01,0,0), 1'b1, rb(), zero, rop(), "beq_exec");
      JR:  step(mk(0,0,0,0,1,2'b10,0,0,0,2'b00,0,0), 1'b0, rb(), rb(), rop(), "jr_exec");
      default: step(mk(0,0,0,0,0,2'b00,0,0,imm,aop,0,0), 1'b1, rb(), rb(), rop(), "exec");
    endcase
    if ((op == ADD) || (op == SUB) || (op == ADDI))
      step(mk(0,0,0,0,0,2'b00,1,0,imm,aop,0,0), 1'b1, rb(), rb(), rop(), "wb");
    if (is_lw || is_sw) begin
      for (int i = 0; i < ((mw < TO) ? mw : TO); i++)
        step(mk(1,is_sw,1,0,0,2'b00,0,0,0,2'b00,0,0), 1'b0, 1'b0, rb(), rop(), "mem_wait");
      if (mw >= TO) begin
        fault_tail();
        return;
      end
      step(mk(1,is_sw,1,0,0,2'b00,is_lw,is_lw,0,2'b00,0,0), 1'b0, 1'b1, rb(), rop(), "mem_ack");
    end
  endtask

  task automatic rand_prog(input int n);
    for (int i = 0; i < n; i++)
      run(3'($urandom_range(0, 6)), $urandom_range(0, 3), $urandom_range(0, 3), rb());
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks outputs drop at once.
  task automatic do_reset(input bit exp_req, input string nm);
    #2;
    checks++;
    if (mem_req === exp_req) passed++;
    else $display("FAIL %s_pre: mem_req got %b expected %b", nm, mem_req, exp_req);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs === 14'h0) passed++;
    else $display("FAIL %s_in_reset: outputs got %b expected %b", nm, obs, 14'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (q.size() > 0)) begin
      e = q.pop_front();
      checks++;
      if ((obs & e.care) === (e.v & e.care)) passed++;
      else $display("FAIL %s: outputs got %b expected %b (mask %b)", e.name, obs, e.v, e.care);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    checks++;
    if (obs === 14'h0) passed++;
    else $display("FAIL reset_outputs: got %b expected %b", obs, 14'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(ADDI, 0, 0, 1'b0);
    run(LW,   0, 3, 1'b0);
    run(SW,   1, 3, 1'b0);
    run(BEQ,  0, 0, 1'b1);
    run(BEQ,  2, 0, 1'b0);
    run(JR,   0, 0, 1'b0);
    run(ADD,  1, 0, 1'b0);
    run(SUB,  0, 0, 1'b1);
    rand_prog(40);

    do_reset(1'b1, "reset_mid_fetch");
    run(ADD, 0, 0, 1'b0);
    run(ADD, TO, 0, 1'b0);
    do_reset(1'b0, "reset_from_fault");
    rand_prog(20);
    run(LW, 0, TO, 1'b0);
    do_reset(1'b0, "reset_from_mem_fault");
    rand_prog(10);
    run(HALT, 1, 0, 1'b0);
    do_reset(1'b0, "reset_from_halt");
    run(ADDI, 0, 0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drained: %0d entries left, expected 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
